// File: rtl/rf_ctrl_pkg.sv
// Shared types and default widths for the register-file access arbiter.
// The opcode and FSM state encodings are fixed here so that checkers can bind to them.
package rf_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_COPY  = 2'b10,
        OP_SWAP  = 2'b11
    } op_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SWAP_B = 1'b1
    } state_t;

endpackage

// File: rtl/rf_access_arbiter_if.sv
// Requester-side bundle: two request channels with a shared response word pair.
// Index 0 is the core and index 1 is the debug/loader port.
interface rf_access_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][1:0]        req_op;
    logic [1:0][ADDR_W-1:0] req_a;
    logic [1:0][ADDR_W-1:0] req_b;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             resp_valid;
    logic [DATA_W-1:0]      resp_data1;
    logic [DATA_W-1:0]      resp_data2;

    modport master (
        output req_valid, req_op, req_a, req_b, req_wdata,
        input  req_ready, resp_valid, resp_data1, resp_data2
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_wdata,
        output req_ready, resp_valid, resp_data1, resp_data2
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way grant: round-robin between requesters, or fixed priority favouring
// requester 0 when PRIO_MODE is nonzero. The grant is combinational.
module rr_arbiter_2 #(
    parameter int PRIO_MODE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // ptr == 0 means requester 0 wins the next tie.
    logic ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            if (PRIO_MODE != 0 || !ptr) grant = 2'b01;
            else                        grant = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      ptr <= 1'b0;
        else if (accept) ptr <= grant[0];
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Arbitrates two requesters onto one register file and sequences READ, WRITE,
// COPY (one cycle) and SWAP (two cycles), returning a one-cycle response pulse.
module rf_access_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int PRIO_MODE = 0
) (
    input  logic               clk,
    input  logic               reset,
    rf_access_arbiter_if.slave bus,
    output logic               busy,
    output logic [ADDR_W-1:0]  rf_reg1,
    output logic [ADDR_W-1:0]  rf_reg2,
    output logic               rf_write,
    output logic [DATA_W-1:0]  rf_write_data,
    input  logic [DATA_W-1:0]  rf_data1,
    input  logic [DATA_W-1:0]  rf_data2,
    output state_t             dbg_state
);

    // Handshake: a request is taken in any cycle where req_valid[i] and
    // req_ready[i] are both 1; at most one ready bit is set, only in IDLE and
    // never under reset. resp_valid is a one-cycle pulse with no backpressure.
    state_t            state_q, state_d;
    logic [1:0]        grant;
    logic              idle_en, accept, w;
    op_t               w_op;
    logic [DATA_W-1:0] tmp_a;
    logic [ADDR_W-1:0] b_q;
    logic              owner_q;
    logic [1:0]        resp_valid_q;
    logic [DATA_W-1:0] resp_data1_q, resp_data2_q;

    assign idle_en = (state_q == S_IDLE) && reset;

    rr_arbiter_2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.req_valid & {2{idle_en}}),
        .accept (accept),
        .grant  (grant)
    );

    assign accept         = |grant;
    assign w              = grant[1];
    assign w_op           = op_t'(bus.req_op[w]);
    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data1 = resp_data1_q;
    assign bus.resp_data2 = resp_data2_q;
    assign busy           = (state_q != S_IDLE);
    assign dbg_state      = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && w_op == OP_SWAP) state_d = S_SWAP_B;
            S_SWAP_B: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // In SWAP_B reg2 also points at b: after the first write rf[b] still holds
    // the old b value (or, when a==b, the same value), so it feeds response word 2.
    always_comb begin
        rf_reg1       = '0;
        rf_reg2       = '0;
        rf_write      = 1'b0;
        rf_write_data = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rf_reg1       = bus.req_a[w];
                    rf_reg2       = bus.req_b[w];
                    rf_write      = (w_op != OP_READ);
                    rf_write_data = (w_op == OP_WRITE) ? bus.req_wdata[w] : rf_data2;
                end
            end
            S_SWAP_B: begin
                rf_reg1       = b_q;
                rf_reg2       = b_q;
                rf_write      = 1'b1;
                rf_write_data = tmp_a;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 2'b00;
            resp_data1_q <= '0;
            resp_data2_q <= '0;
            tmp_a        <= '0;
            b_q          <= '0;
            owner_q      <= 1'b0;
        end else begin
            resp_valid_q <= 2'b00;
            if (state_q == S_SWAP_B) begin
                resp_valid_q[owner_q] <= 1'b1;
                resp_data1_q          <= tmp_a;
                resp_data2_q          <= rf_data2;
            end else if (accept) begin
                case (w_op)
                    OP_READ: begin
                        resp_valid_q[w] <= 1'b1;
                        resp_data1_q    <= rf_data1;
                        resp_data2_q    <= rf_data2;
                    end
                    OP_WRITE: begin
                        resp_valid_q[w] <= 1'b1;
                        resp_data1_q    <= bus.req_wdata[w];
                        resp_data2_q    <= '0;
                    end
                    OP_COPY: begin
                        resp_valid_q[w] <= 1'b1;
                        resp_data1_q    <= rf_data2;
                        resp_data2_q    <= rf_data2;
                    end
                    OP_SWAP: begin
                        tmp_a   <= rf_data1;
                        b_q     <= bus.req_b[w];
                        owner_q <= w;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed and random checks of rf_access_arbiter against an array model of the
// register file; one round-robin and one fixed-priority instance.
module tb_rf_access_arbiter;
    import rf_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rf_access_arbiter_if bus0 ();
    rf_access_arbiter_if bus1 ();

    logic        busy0, busy1, rf_write_0, rf_write_1;
    logic [1:0]  reg1_0, reg2_0, reg1_1, reg2_1;
    logic [15:0] wdat_0, wdat_1, rd1_0, rd2_0, rd1_1, rd2_1;
    state_t      st0, st1;

    rf_access_arbiter #(.PRIO_MODE(0)) u_rr (
        .clk(clk), .reset(reset), .bus(bus0), .busy(busy0),
        .rf_reg1(reg1_0), .rf_reg2(reg2_0), .rf_write(rf_write_0),
        .rf_write_data(wdat_0), .rf_data1(rd1_0), .rf_data2(rd2_0), .dbg_state(st0)
    );

    rf_access_arbiter #(.PRIO_MODE(1)) u_fp (
        .clk(clk), .reset(reset), .bus(bus1), .busy(busy1),
        .rf_reg1(reg1_1), .rf_reg2(reg2_1), .rf_write(rf_write_1),
        .rf_write_data(wdat_1), .rf_data1(rd1_1), .rf_data2(rd2_1), .dbg_state(st1)
    );

    // Register files attached to each instance: write at reg1, combinational reads.
    logic [15:0] rf0 [4] = '{default: 16'h0};
    logic [15:0] rf1 [4] = '{default: 16'h0};
    int          wr_cnt0 = 0;
    assign rd1_0 = rf0[reg1_0];
    assign rd2_0 = rf0[reg2_0];
    assign rd1_1 = rf1[reg1_1];
    assign rd2_1 = rf1[reg2_1];
    always @(posedge clk) begin
        if (rf_write_0) begin
            rf0[reg1_0] <= wdat_0;
            wr_cnt0     <= wr_cnt0 + 1;
        end
        if (rf_write_1) rf1[reg1_1] <= wdat_1;
    end

    logic [15:0] model [4] = '{default: 16'h0};
    int checks = 0;
    int passed = 0;
    int last_w = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One operation on the round-robin instance from requester r, checked end to end.
    task automatic do_op(input int r, input op_t op, input logic [1:0] a, input logic [1:0] b,
                         input logic [15:0] wd);
        logic [15:0] e1, e2;
        int n, wr0, nwr;
        bus0.req_op[r]    = op;
        bus0.req_a[r]     = a;
        bus0.req_b[r]     = b;
        bus0.req_wdata[r] = wd;
        bus0.req_valid    = 2'b00;
        bus0.req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (bus0.req_ready[r] !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout", n < 20, 1'b1);
        chk("ready", bus0.req_ready, 2'b01 << r);
        chk("wr_en_accept", rf_write_0, op != OP_READ);
        chk("reg1_accept", reg1_0, a);
        case (op)
            OP_READ:  begin e1 = model[a]; e2 = model[b]; nwr = 0; end
            OP_WRITE: begin e1 = wd; e2 = 16'h0; model[a] = wd; nwr = 1; end
            OP_COPY:  begin e1 = model[b]; e2 = model[b]; model[a] = e1; nwr = 1; end
            default:  begin e1 = model[a]; e2 = model[b]; model[a] = e2; model[b] = e1; nwr = 2; end
        endcase
        wr0 = wr_cnt0;
        @(posedge clk); #1;
        bus0.req_valid = 2'b00;
        if (op == OP_SWAP) begin
            bus0.req_valid = 2'b11;
            #1;
            chk("swapb_busy", busy0, 1'b1);
            chk("swapb_state", st0, S_SWAP_B);
            chk("swapb_ready", bus0.req_ready, 2'b00);
            chk("swapb_wr_en", rf_write_0, 1'b1);
            chk("swapb_reg1", reg1_0, b);
            chk("swapb_no_resp", bus0.resp_valid, 2'b00);
            bus0.req_valid = 2'b00;
            @(posedge clk); #1;
        end
        chk("resp_valid", bus0.resp_valid, 2'b01 << r);
        chk("resp_data1", bus0.resp_data1, e1);
        chk("resp_data2", bus0.resp_data2, e2);
        chk("busy_after", busy0, 1'b0);
        chk("write_count", wr_cnt0 - wr0, nwr);
        @(posedge clk); #1;
        chk("resp_pulse", bus0.resp_valid, 2'b00);
        chk("resp_hold", bus0.resp_data1, e1);
        chk("write_count_late", wr_cnt0 - wr0, nwr);
        last_w = r;
    endtask

    initial begin
        logic [15:0] e1, e2, olda, oldb;
        logic [1:0]  ca [2];
        logic [1:0]  cb [2];
        int ew, wr0;

        bus0.req_valid = 2'b11; bus0.req_op = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.req_wdata = '0;
        bus1.req_valid = 2'b11; bus1.req_op = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", bus0.req_ready, 2'b00);
        chk("rst_ready1", bus1.req_ready, 2'b00);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_wr_en", rf_write_0, 1'b0);
        chk("rst_reg1", reg1_0, 2'd0);
        chk("rst_reg2", reg2_0, 2'd0);
        chk("rst_resp_valid", bus0.resp_valid, 2'b00);
        chk("rst_resp_data1", bus0.resp_data1, 16'h0);
        chk("rst_resp_data2", bus0.resp_data2, 16'h0);
        chk("rst_state", st0, S_IDLE);
        bus0.req_valid = 2'b00;
        bus1.req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_reg1", reg1_0, 2'd0);
        chk("idle_wr_en", rf_write_0, 1'b0);

        do_op(0, OP_WRITE, 2'd2, 2'd0, 16'hBEEF);
        do_op(0, OP_READ, 2'd2, 2'd0, 16'h0);

        // Round-robin contention: both hold READs valid for four cycles.
        ca[0] = 2'd2; cb[0] = 2'd0; ca[1] = 2'd1; cb[1] = 2'd3;
        for (int i = 0; i < 2; i++) begin
            bus0.req_op[i] = OP_READ;
            bus0.req_a[i]  = ca[i];
            bus0.req_b[i]  = cb[i];
        end
        ew = (last_w == 0) ? 1 : 0;
        bus0.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", bus0.req_ready, 2'b01 << ew);
            e1 = model[ca[ew]];
            e2 = model[cb[ew]];
            @(posedge clk); #1;
            chk("rr_resp_valid", bus0.resp_valid, 2'b01 << ew);
            chk("rr_resp_data1", bus0.resp_data1, e1);
            chk("rr_resp_data2", bus0.resp_data2, e2);
            last_w = ew;
            ew = 1 - ew;
        end
        bus0.req_valid = 2'b00;

        // Fixed priority: requester 0 takes every cycle.
        bus1.req_a[0] = 2'd1; bus1.req_b[0] = 2'd2;
        bus1.req_a[1] = 2'd3; bus1.req_b[1] = 2'd0;
        bus1.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("fp_grant", bus1.req_ready, 2'b01);
            @(posedge clk); #1;
            chk("fp_resp_valid", bus1.resp_valid, 2'b01);
        end
        bus1.req_valid = 2'b00;
        @(posedge clk); #1;

        do_op(0, OP_WRITE, 2'd1, 2'd0, 16'h1111);
        do_op(0, OP_WRITE, 2'd3, 2'd0, 16'h3333);
        do_op(1, OP_SWAP, 2'd1, 2'd3, 16'h0);
        do_op(0, OP_READ, 2'd1, 2'd3, 16'h0);
        do_op(1, OP_WRITE, 2'd3, 2'd0, 16'h00A5);
        do_op(0, OP_COPY, 2'd0, 2'd3, 16'h0);
        do_op(0, OP_WRITE, 2'd2, 2'd0, 16'h7777);
        do_op(1, OP_SWAP, 2'd2, 2'd2, 16'h0);
        chk("swap_same_rf2", rf0[2], 16'h7777);

        for (int i = 0; i < 30; i++) begin
            do_op(int'($urandom_range(0, 1)), op_t'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom()));
        end

        // Reset while in SWAP_B: first write stays, second is dropped, no response.
        olda = model[1];
        oldb = model[3];
        bus0.req_op[0] = OP_SWAP; bus0.req_a[0] = 2'd1; bus0.req_b[0] = 2'd3;
        bus0.req_valid = 2'b01;
        #1;
        chk("rst_swap_ready", bus0.req_ready, 2'b01);
        wr0 = wr_cnt0;
        @(posedge clk); #1;
        bus0.req_valid = 2'b11;
        chk("rst_swap_busy", busy0, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_swap_ready0", bus0.req_ready, 2'b00);
        chk("rst_swap_busy0", busy0, 1'b0);
        chk("rst_swap_wr_en", rf_write_0, 1'b0);
        chk("rst_swap_reg1", reg1_0, 2'd0);
        @(posedge clk); #1;
        chk("rst_swap_no_resp", bus0.resp_valid, 2'b00);
        chk("rst_swap_state", st0, S_IDLE);
        chk("rst_swap_writes", wr_cnt0 - wr0, 1);
        model[1] = oldb;
        chk("rst_swap_rf_a", rf0[1], oldb);
        chk("rst_swap_rf_b", rf0[3], oldb);
        reset = 1'b1;
        bus0.req_op[1] = OP_READ;
        #1;
        chk("rst_prefers_0", bus0.req_ready, 2'b01);
        bus0.req_valid = 2'b00;
        @(posedge clk); #1;
        chk("post_rst_no_resp", bus0.resp_valid, 2'b00);

        for (int i = 0; i < 4; i++) chk("final_rf", rf0[i], model[i]);
        if (olda === oldb) chk("rst_swap_same", rf0[1], olda);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
